// File: rtl/wb_burst_reader_pkg.sv
// Shared types and helpers for the Wishbone burst reader.
// Holds the controller state encoding and the per-word address step.
package wb_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    WAIT_SPACE
  } state_t;

  // Byte address increment between consecutive words on the bus.
  function automatic int unsigned byte_step(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/wb_burst_reader_if.sv
// Classic Wishbone bus bundle between a single master and slave.
// Signal directions in the names follow the master's point of view.
interface if_wb #(
  parameter int AWIDTH = 26,
  parameter int DWIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [DWIDTH/8-1:0]   sel;
  logic [AWIDTH-1:0]     adr;
  logic [DWIDTH-1:0]     dat_o;
  logic [DWIDTH-1:0]     dat_i;
  logic                  ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack
  );
endinterface

// File: rtl/wb_burst_reader_fifo_sync.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the count gates what is considered valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone master streaming a contiguous block of words into a local FIFO,
// releasing cyc every BURST beats and whenever the FIFO is nearly full.
module wb_burst_reader
  import wb_burst_reader_pkg::*;
#(
  parameter int AWIDTH     = 26,
  parameter int DWIDTH     = 32,
  parameter int LWIDTH     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.master              bus,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_i,
  input  logic [LWIDTH-1:0] len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i
);
  localparam int STEP = byte_step(DWIDTH);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int BW   = $clog2(BURST + 1);

  state_t            state;
  logic [AWIDTH-1:0] adr_q;
  logic [LWIDTH-1:0] remaining;
  logic [BW-1:0]     beats;
  logic              cyc_q;
  logic              abort_pending;

  logic              ack_beat;
  logic              abort_now;
  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic              room;

  assign bus.cyc   = cyc_q;
  assign bus.stb   = cyc_q;
  assign bus.we    = 1'b0;
  assign bus.sel   = '1;
  assign bus.adr   = adr_q;
  assign bus.dat_o = '0;

  assign ack_beat  = (state == REQ) && bus.ack;
  assign abort_now = abort_i || abort_pending;
  // An abort discards the beat it waited for, even if it is the last one.
  assign push      = ack_beat && !abort_now;
  assign pop       = valid_o && ready_i;
  assign flush     = (ack_beat && abort_now) ||
                     (((state == GAP) || (state == WAIT_SPACE)) && abort_i);
  assign valid_o   = !fifo_empty;

  assign count_next = fifo_count + CW'(push) - CW'(pop);
  // Entering REQ only with two free slots leaves room for the single
  // outstanding beat, so an ack can never be dropped.
  assign room       = fifo_count <= CW'(FIFO_DEPTH - 2);

  fifo_sync #(
    .WIDTH (DWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush),
    .push      (push),
    .push_data (bus.dat_i),
    .pop       (pop),
    .head      (data_o),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      adr_q         <= '0;
      remaining     <= '0;
      beats         <= '0;
      cyc_q         <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      abort_pending <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              adr_q         <= base_i & ~AWIDTH'(STEP - 1);
              remaining     <= len_i;
              beats         <= '0;
              busy_o        <= 1'b1;
              abort_pending <= 1'b0;
              if (room) begin
                state <= REQ;
                cyc_q <= 1'b1;
              end else begin
                state <= WAIT_SPACE;
              end
            end
          end
        end

        REQ: begin
          if (ack_beat) begin
            adr_q     <= adr_q + AWIDTH'(STEP);
            remaining <= remaining - LWIDTH'(1);
            beats     <= beats + BW'(1);
            if (abort_now) begin
              state         <= IDLE;
              cyc_q         <= 1'b0;
              busy_o        <= 1'b0;
              abort_pending <= 1'b0;
            end else if (remaining == LWIDTH'(1)) begin
              state  <= IDLE;
              cyc_q  <= 1'b0;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else if (beats == BW'(BURST - 1)) begin
              state <= GAP;
              cyc_q <= 1'b0;
              beats <= '0;
            end else if (count_next >= CW'(FIFO_DEPTH - 1)) begin
              state <= WAIT_SPACE;
              cyc_q <= 1'b0;
              beats <= '0;
            end
          end else if (abort_i) begin
            abort_pending <= 1'b1;
          end
        end

        GAP, WAIT_SPACE: begin
          if (abort_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (room) begin
            state <= REQ;
            cyc_q <= 1'b1;
          end else begin
            state <= WAIT_SPACE;
          end
        end

        default: begin
          state <= IDLE;
          cyc_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: a wait-state Wishbone slave,
// a stream consumer, and a queue-based model of expected addresses and data.
module tb_wb_burst_reader;

  localparam int AW    = 26;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 16;
  localparam int BURST = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i;
  logic [AW-1:0] base_i;
  logic [LW-1:0] len_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;

  int            n_tests = 0;
  int            n_fail  = 0;

  if_wb #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  wb_burst_reader #(
    .AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .FIFO_DEPTH(DEPTH), .BURST(BURST)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus.master),
    .start_i (start_i),
    .base_i  (base_i),
    .len_i   (len_i),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  // Slave: combinational ack after wait_cycles of stb, data is a hash of adr.
  int wait_cycles = 0;
  int wcnt;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return ({6'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.ack   = bus.cyc && bus.stb && (wcnt >= wait_cycles);
  assign bus.dat_i = data_of(bus.adr);

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.cyc && bus.stb && !bus.ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Consumer: 0 = stalled, 1 = always ready, 2 = random.
  int   ready_mode = 0;
  logic rnd = 1'b0;
  assign ready_i = (ready_mode == 1) || ((ready_mode == 2) && rnd);

  always @(posedge clk) begin
    #1;
    rnd = 1'($urandom_range(0, 1));
  end

  // Reference model and observation state.
  logic [AW-1:0] exp_adr[$];
  logic [DW-1:0] exp_data[$];
  int            beats_xfer, dones, gaps, low_run, max_low, stored, max_stored;
  int            gap_pos[$];
  logic [AW-1:0] last_adr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_o && beats_xfer > 0 && !bus.cyc) begin
        low_run++;
      end else if (bus.cyc && low_run > 0) begin
        gaps++;
        gap_pos.push_back(beats_xfer);
        if (low_run > max_low) max_low = low_run;
        low_run = 0;
      end
      if (bus.cyc && bus.stb && bus.ack) begin
        beats_xfer++;
        stored++;
        last_adr = bus.adr;
        check("ack_expected", 64'(exp_adr.size() > 0), 1);
        if (exp_adr.size() > 0) check("ack_adr", bus.adr, exp_adr.pop_front());
      end
      if (valid_o && ready_i) begin
        stored--;
        check("pop_expected", 64'(exp_data.size() > 0), 1);
        if (exp_data.size() > 0) check("pop_data", data_o, exp_data.pop_front());
      end
      if (stored > max_stored) max_stored = stored;
      if (done_o) dones++;
    end
  end

  task automatic start_xfer(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start_i = 1'b1;
    base_i  = base;
    len_i   = LW'(len);
    beats_xfer = 0; dones = 0; gaps = 0; low_run = 0; max_low = 0;
    gap_pos.delete();
    for (int i = 0; i < len; i++) begin
      a = (base & ~AW'(3)) + AW'(4 * i);
      exp_adr.push_back(a);
      exp_data.push_back(data_of(a));
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("idle_in_time", 64'(busy_o), 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    ready_mode = 1;
    while ((exp_data.size() > 0 || valid_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_model_empty", 64'(exp_data.size()), 0);
    check("drain_valid_low", 64'(valid_o), 0);
  endtask

  task automatic clear_model();
    exp_adr.delete();
    exp_data.delete();
    stored = 0;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            wait_c;
    int            exp_beats;
    int            exp_done;
    int            exp_gaps;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 26'h100,     len: 4,  wait_c: 0, exp_beats: 4,  exp_done: 1, exp_gaps: 0, exp_last: 26'h10C};
    vecs[1] = '{base: 26'h2000,    len: 20, wait_c: 0, exp_beats: 20, exp_done: 1, exp_gaps: 2, exp_last: 26'h204C};
    vecs[2] = '{base: 26'h3FFFFF8, len: 4,  wait_c: 0, exp_beats: 4,  exp_done: 1, exp_gaps: 0, exp_last: 26'h4};
    vecs[3] = '{base: 26'h103,     len: 3,  wait_c: 2, exp_beats: 3,  exp_done: 1, exp_gaps: 0, exp_last: 26'h108};
    vecs[4] = '{base: 26'h300,     len: 0,  wait_c: 0, exp_beats: 0,  exp_done: 1, exp_gaps: 0, exp_last: 26'h0};
    vecs[5] = '{base: 26'h40,      len: 8,  wait_c: 0, exp_beats: 8,  exp_done: 1, exp_gaps: 0, exp_last: 26'h5C};
    vecs[6] = '{base: 26'h80,      len: 9,  wait_c: 1, exp_beats: 9,  exp_done: 1, exp_gaps: 1, exp_last: 26'hA0};

    start_i = 1'b0; base_i = '0; len_i = '0; abort_i = 1'b0;
    beats_xfer = 0; dones = 0; gaps = 0; low_run = 0; max_low = 0;
    stored = 0; max_stored = 0; last_adr = '0;

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("rst_cyc", 64'(bus.cyc), 0);
    check("rst_stb", 64'(bus.stb), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_valid", 64'(valid_o), 0);
    check("fixed_we", 64'(bus.we), 0);
    check("fixed_sel", 64'(bus.sel), 64'hF);
    check("fixed_dat_o", 64'(bus.dat_o), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: address sequence, burst gaps, wrap, alignment, len 0.
    for (int v = 0; v < 7; v++) begin
      wait_cycles = vecs[v].wait_c;
      ready_mode  = 1;
      start_xfer(vecs[v].base, vecs[v].len);
      check("cyc_idle_for_len0", 64'(vecs[v].len == 0 && bus.cyc), 0);
      wait_idle(400);
      drain(100);
      check("vec_beats", 64'(beats_xfer), 64'(vecs[v].exp_beats));
      check("vec_done", 64'(dones), 64'(vecs[v].exp_done));
      check("vec_gaps", 64'(gaps), 64'(vecs[v].exp_gaps));
      if (vecs[v].len > 0) check("vec_last_adr", last_adr, vecs[v].exp_last);
      if (vecs[v].exp_gaps > 0) check("vec_gap_len", 64'(max_low), 1);
      for (int k = 0; k < gap_pos.size(); k++)
        check("vec_gap_pos", 64'(gap_pos[k]), 64'(BURST * (k + 1)));
    end

    // Stalled consumer: transfer parks with the FIFO nearly full, then resumes.
    wait_cycles = 0; ready_mode = 0; max_stored = 0;
    start_xfer(26'h1000, 40);
    repeat (40) @(negedge clk);
    check("full_cyc_low", 64'(bus.cyc), 0);
    check("full_busy", 64'(busy_o), 1);
    check("full_stored_15_16", 64'(stored >= DEPTH - 1 && stored <= DEPTH), 1);
    ready_mode = 1;
    wait_idle(600);
    drain(100);
    check("full_beats", 64'(beats_xfer), 40);
    check("full_done", 64'(dones), 1);
    check("full_no_overflow", 64'(max_stored <= DEPTH), 1);

    // start_i while busy is ignored.
    wait_cycles = 2; ready_mode = 1;
    start_xfer(26'h500, 4);
    @(posedge clk); #1;
    start_i = 1'b1; base_i = 26'h900; len_i = 16'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle(200);
    drain(100);
    check("busy_start_beats", 64'(beats_xfer), 4);
    check("busy_start_done", 64'(dones), 1);
    check("busy_start_last", last_adr, 26'h50C);

    // Abort while a slow beat is pending: beat completes, data flushed.
    wait_cycles = 3; ready_mode = 0;
    start_xfer(26'h600, 6);
    for (int n = 0; n < 100 && beats_xfer < 2; n++) @(negedge clk);
    @(posedge clk); #1;
    check("abort_pre_valid", 64'(valid_o), 1);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_stb_held", 64'(bus.stb), 1);
    wait_idle(100);
    check("abort_beats", 64'(beats_xfer), 3);
    check("abort_no_done", 64'(dones), 0);
    check("abort_valid", 64'(valid_o), 0);
    check("abort_cyc", 64'(bus.cyc), 0);
    clear_model();

    // Abort coinciding with the final ack: abort wins.
    wait_cycles = 2; ready_mode = 0;
    start_xfer(26'h700, 3);
    for (int n = 0; n < 100 && !(bus.ack && bus.adr == 26'h708); n++) @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_idle(50);
    check("abort_last_beats", 64'(beats_xfer), 3);
    check("abort_last_no_done", 64'(dones), 0);
    check("abort_last_valid", 64'(valid_o), 0);
    clear_model();

    // Abort while parked waiting for FIFO space: idle on the next cycle.
    wait_cycles = 0; ready_mode = 0;
    start_xfer(26'h800, 40);
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    check("abort_wait_busy", 64'(busy_o), 0);
    check("abort_wait_valid", 64'(valid_o), 0);
    repeat (2) @(negedge clk);
    check("abort_wait_no_done", 64'(dones), 0);
    clear_model();

    // Asynchronous reset mid-burst, then a normal transfer.
    wait_cycles = 0; ready_mode = 0;
    start_xfer(26'hA00, 20);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_cyc", 64'(bus.cyc), 0);
    check("mid_rst_stb", 64'(bus.stb), 0);
    check("mid_rst_busy", 64'(busy_o), 0);
    check("mid_rst_valid", 64'(valid_o), 0);
    clear_model();
    @(posedge clk); #1 rst = 1'b0;
    ready_mode = 1;
    start_xfer(26'h0, 2);
    wait_idle(50);
    drain(50);
    check("post_rst_beats", 64'(beats_xfer), 2);
    check("post_rst_done", 64'(dones), 1);

    // Randomized transfers, random consumer, FIFO sometimes left non-empty.
    max_stored = 0;
    for (int t = 0; t < 30; t++) begin
      logic [AW-1:0] b;
      int            l;
      b = AW'($urandom);
      l = $urandom_range(0, 30);
      wait_cycles = $urandom_range(0, 2);
      ready_mode  = 2;
      start_xfer(b, l);
      wait_idle(2000);
      check("rand_beats", 64'(beats_xfer), 64'(l));
      check("rand_done", 64'(dones), 1);
      if ($urandom_range(0, 3) == 0) drain(200);
    end
    drain(200);
    check("rand_no_overflow", 64'(max_stored <= DEPTH), 1);
    check("rand_adr_model_empty", 64'(exp_adr.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
Wishbone master that streams a contiguous block of 32-bit words out of SDRAM into a local FIFO. It is the initiator counterpart of the arbitrated, cached SDRAM controller, and plugs into one of that controller's bus0/bus1 slave ports. Consumers such as a video line fetcher or a DMA sink drain the data through a valid/ready stream. The block releases cyc periodically and whenever its FIFO fills, so the arbiter can grant the other port.

Parameters:
AWIDTH, 26, byte-address width on the Wishbone bus
DWIDTH, 32, data width; address step per word is DWIDTH/8
LWIDTH, 16, width of the word-count input
FIFO_DEPTH, 16, output FIFO entries; power of two, >=2
BURST, 8, maximum beats per cyc assertion before a forced one-cycle release

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
bus  if_wb.master  -  drives cyc, stb, we, sel, adr, dat_o; samples ack, dat_i
start_i  in  1  start pulse; base_i and len_i sampled on the same edge
base_i  in  AWIDTH  start byte address; low log2(DWIDTH/8) bits forced to 0
len_i  in  LWIDTH  number of words to read; 0 is legal
abort_i  in  1  abandon the transfer in progress
busy_o  out  1  high from the start edge until done or abort completes
done_o  out  1  one-cycle pulse when the last word has been written to the FIFO
data_o  out  DWIDTH  FIFO head (first-word fall-through)
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer pop; a pop occurs when valid_o && ready_i

Behaviour:
- Reset (asynchronous, active-high): cyc, stb, busy_o, done_o and valid_o are 0. FIFO is empty. State is IDLE. Address and counters are 0.
- Fixed outputs in all states: we=0, sel=all ones, dat_o=0.
- States:
  - IDLE -> REQ on start_i with len_i != 0: latch base_i and len_i; beat count = 0.
  - IDLE on start_i with len_i == 0: done_o pulses on the next cycle; no bus activity.
  - start_i is ignored while busy_o = 1.
  - REQ: cyc=stb=1, adr = current address. stb is held until ack; there is only ever one outstanding beat.
- On each ack edge:
  - push dat_i into the FIFO;
  - address += DWIDTH/8 (wraps modulo 2^AWIDTH);
  - remaining -= 1; beat count += 1.
- Next state after an ack:
  - remaining == 0 -> IDLE; cyc/stb drop on the following cycle; done_o pulses that cycle.
  - beat count == BURST -> GAP (cyc=0 for exactly one cycle, beat count cleared) -> REQ.
  - FIFO count after push and pop >= FIFO_DEPTH-1 -> WAIT_SPACE (cyc=0, beat count cleared).
  - otherwise stay in REQ. stb stays high back-to-back, so a zero-wait slave gives 1 word per cycle.
- WAIT_SPACE -> REQ when FIFO count <= FIFO_DEPTH-2. This guarantees room for the outstanding beat, so the FIFO can never overflow and no acked data is lost.
- abort_i:
  - in REQ: keep stb/cyc until the pending ack, discard that word, then go to IDLE.
  - in GAP or WAIT_SPACE: go to IDLE next cycle.
  - In both cases the FIFO is flushed, busy_o drops, and done_o does not pulse.
  - If abort_i and the final ack coincide, the abort wins: no done_o, FIFO flushed.
- FIFO:
  - a simultaneous push and pop in the same cycle is legal; count is unchanged;
  - a pop when empty is ignored;
  - data_o is undefined when valid_o = 0;
  - word order is preserved exactly.
- done_o does not wait for the consumer to drain the FIFO. A new start_i is accepted after done_o even if the FIFO is still non-empty; its data appends in order.

Decomposition:
- Package wb_burst_reader_pkg: state enum (IDLE, REQ, GAP, WAIT_SPACE) and the function computing the byte step from DWIDTH.
- One sub-module, fifo_sync: a parameterised first-word-fall-through synchronous FIFO with count output and flush input. It is reusable elsewhere in the library.

Test Plan:
1. base=0x100, len=4, zero-wait slave, ready_i=1 -> adr 0x100,0x104,0x108,0x10C in one continuous cyc; data out in order; a single done_o pulse; busy_o low afterwards.
2. len=20, BURST=8 -> cyc low for exactly one cycle after beats 8 and 16; 20 acks total; done_o once.
3. len=40, ready_i=0, FIFO_DEPTH=16 -> cyc drops with 15 or 16 words stored and never overflows; raise ready_i -> transfer resumes; all 40 words emerge in order.
4. len=0 -> done_o one cycle after start_i; cyc never asserted; start_i during busy (len=4 running) -> ignored; exactly 4 beats.
5. abort_i while stb is high and the slave delays ack 3 cycles -> stb held until ack, then cyc=0, valid_o=0, busy_o=0, no done_o; abort coinciding with the last ack -> no done_o.
6. rst_i asserted mid-burst (between clock edges) -> cyc, stb, busy_o and valid_o go to 0 immediately; after release, start base=0x0, len=2 completes normally.
